// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types, encodings and defaults for the pipeline controller
//
// Contents:
//   DIV_CYCLES_DEF / MUL_CYCLES_DEF  default step counts for the mul/div unit
//   md_state_t                       mul/div sequencer states
//   FWD_REG / FWD_MEM / FWD_WB       EX operand forwarding select encodings
//   fwd_sel()                        EX forwarding select for one source register
//   op_hit()                         "used, nonzero source matches destination" test
package cpu_pkg;

    localparam int DIV_CYCLES_DEF = 32;
    localparam int MUL_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_MUL  = 2'd1,
        MD_DIV  = 2'd2,
        MD_DONE = 2'd3
    } md_state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // EX/MEM has priority over MEM/WB because it holds the younger result.
    // r0 is hardwired to zero and is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_wreg,
        input logic       mem_regwen,
        input logic [4:0] wb_wreg,
        input logic       wb_regwen
    );
        if (src == 5'd0)
            return FWD_REG;
        else if (mem_regwen && (mem_wreg == src))
            return FWD_MEM;
        else if (wb_regwen && (wb_wreg == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

    function automatic logic op_hit(
        input logic       used,
        input logic [4:0] op,
        input logic [4:0] dst
    );
        return used && (op != 5'd0) && (op == dst);
    endfunction

endpackage

// File: rtl/hazard_cmp.sv
// rtl/hazard_cmp.sv - combinational hazard detection and forwarding compares
//
// Ports:
//   id_*       ID-stage source registers, use flags and branch flag
//   ex_*       EX-stage sources, destination, regwen and load flag
//   mem_*      MEM-stage destination, regwen and load flag
//   wb_*       WB-stage destination and regwen
//   fwd_a/b    EX operand selects (FWD_REG/FWD_MEM/FWD_WB)
//   fwd_id_a/b ID branch compare takes EX/MEM AluOut
//   load_use   ID consumes the result of a load currently in EX
//   br_stall   ID branch needs a value that cannot be forwarded yet
module hazard_cmp
    import cpu_pkg::*;
(
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_wreg,
    input  logic       ex_regwen,
    input  logic       ex_load,
    input  logic [4:0] mem_wreg,
    input  logic       mem_regwen,
    input  logic       mem_load,
    input  logic [4:0] wb_wreg,
    input  logic       wb_regwen,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       fwd_id_a,
    output logic       fwd_id_b,
    output logic       load_use,
    output logic       br_stall
);

    logic ex_hit_rs;
    logic ex_hit_rt;
    logic mem_hit_rs;
    logic mem_hit_rt;

    always_comb begin
        fwd_a = fwd_sel(ex_rs, mem_wreg, mem_regwen, wb_wreg, wb_regwen);
        fwd_b = fwd_sel(ex_rt, mem_wreg, mem_regwen, wb_wreg, wb_regwen);

        ex_hit_rs  = op_hit(id_use_rs, id_rs, ex_wreg);
        ex_hit_rt  = op_hit(id_use_rt, id_rt, ex_wreg);
        mem_hit_rs = op_hit(id_use_rs, id_rs, mem_wreg);
        mem_hit_rt = op_hit(id_use_rt, id_rt, mem_wreg);

        // op_hit already excludes r0, which covers the ex_wreg != 0 term.
        load_use = ex_load && (ex_hit_rs || ex_hit_rt);

        // A branch resolved in ID cannot see an EX result at all, and a load
        // in MEM only has its data at the end of MEM, so both must wait.
        br_stall = id_is_branch &&
                   ((ex_regwen && (ex_hit_rs || ex_hit_rt)) ||
                    (mem_load  && (mem_hit_rs || mem_hit_rt)));

        fwd_id_a = mem_regwen && !mem_load && mem_hit_rs;
        fwd_id_b = mem_regwen && !mem_load && mem_hit_rt;
    end

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline hazard/forwarding control and mul/div sequencer
//
// Ports:
//   clk, reset            clock and asynchronous active-high reset
//   id_*, ex_*, mem_*,    register numbers and control flags of the
//   wb_*                  instructions in each pipeline stage
//   ex_md_start/ex_md_div valid mult/div in EX, divide select
//   exc_flush             exception/eret committed in MEM
//   stall_pc, stall_ex    hold PC+IF/ID, hold ID/EX
//   bubble_ex, bubble_mem load a NOP into ID/EX, EX/MEM
//   flush_all             clear IF/ID, ID/EX and EX/MEM valid bits
//   fwd_a/b, fwd_id_a/b   operand forwarding selects
//   md_load, md_step      mul/div unit operand latch and step strobes
//   md_done, md_busy      registered HI/LO write pulse and busy flag
module pipe_ctrl
    import cpu_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_branch,
    input  logic [4:0] ex_rs,
    input  logic [4:0] ex_rt,
    input  logic [4:0] ex_wreg,
    input  logic       ex_regwen,
    input  logic       ex_load,
    input  logic       ex_md_start,
    input  logic       ex_md_div,
    input  logic [4:0] mem_wreg,
    input  logic       mem_regwen,
    input  logic       mem_load,
    input  logic [4:0] wb_wreg,
    input  logic       wb_regwen,
    input  logic       exc_flush,
    output logic       stall_pc,
    output logic       stall_ex,
    output logic       bubble_ex,
    output logic       bubble_mem,
    output logic       flush_all,
    output logic [1:0] fwd_a,
    output logic [1:0] fwd_b,
    output logic       fwd_id_a,
    output logic       fwd_id_b,
    output logic       md_load,
    output logic       md_step,
    output logic       md_done,
    output logic       md_busy
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    md_state_t   state;
    logic [CW-1:0] count;
    // Set for the one cycle after DONE: the finished mult/div is still in EX
    // with ex_md_start high and must not be started a second time.
    logic        md_hold;

    logic [1:0]  hz_fwd_a;
    logic [1:0]  hz_fwd_b;
    logic        hz_fwd_id_a;
    logic        hz_fwd_id_b;
    logic        hz_load_use;
    logic        hz_br_stall;

    logic        start_ok;
    logic        md_active;
    logic        hz_stall;

    hazard_cmp u_hazard_cmp (
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_use_rs    (id_use_rs),
        .id_use_rt    (id_use_rt),
        .id_is_branch (id_is_branch),
        .ex_rs        (ex_rs),
        .ex_rt        (ex_rt),
        .ex_wreg      (ex_wreg),
        .ex_regwen    (ex_regwen),
        .ex_load      (ex_load),
        .mem_wreg     (mem_wreg),
        .mem_regwen   (mem_regwen),
        .mem_load     (mem_load),
        .wb_wreg      (wb_wreg),
        .wb_regwen    (wb_regwen),
        .fwd_a        (hz_fwd_a),
        .fwd_b        (hz_fwd_b),
        .fwd_id_a     (hz_fwd_id_a),
        .fwd_id_b     (hz_fwd_id_b),
        .load_use     (hz_load_use),
        .br_stall     (hz_br_stall)
    );

    always_comb begin
        start_ok  = (state == MD_IDLE) && ex_md_start && !md_hold && !exc_flush;
        md_active = start_ok || (state != MD_IDLE);
        hz_stall  = hz_load_use || hz_br_stall;

        // Everything below is combinational, so it is forced low while reset
        // is held to give the immediate all-zero output state.
        flush_all  = !reset && exc_flush;
        stall_pc   = !reset && !exc_flush && (md_active || hz_stall);
        stall_ex   = !reset && !exc_flush && md_active;
        bubble_mem = !reset && !exc_flush && md_active;
        // The mul/div ID/EX hold already keeps the dependent instruction in
        // ID, so a coincident load-use/branch bubble is suppressed.
        bubble_ex  = !reset && !exc_flush && !md_active && hz_stall;

        md_load    = !reset && start_ok;
        md_step    = !reset && !exc_flush &&
                     ((state == MD_MUL) || (state == MD_DIV));

        fwd_a      = reset ? FWD_REG : hz_fwd_a;
        fwd_b      = reset ? FWD_REG : hz_fwd_b;
        fwd_id_a   = !reset && hz_fwd_id_a;
        fwd_id_b   = !reset && hz_fwd_id_b;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= MD_IDLE;
            count   <= '0;
            md_hold <= 1'b0;
            md_done <= 1'b0;
            md_busy <= 1'b0;
        end else if (exc_flush) begin
            state   <= MD_IDLE;
            count   <= '0;
            md_hold <= 1'b0;
            md_done <= 1'b0;
            md_busy <= 1'b0;
        end else begin
            case (state)
                MD_IDLE: begin
                    md_hold <= 1'b0;
                    md_done <= 1'b0;
                    if (start_ok) begin
                        state   <= ex_md_div ? MD_DIV : MD_MUL;
                        count   <= ex_md_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                        md_busy <= 1'b1;
                    end else begin
                        md_busy <= 1'b0;
                    end
                end
                MD_MUL, MD_DIV: begin
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        state   <= MD_DONE;
                        md_done <= 1'b1;
                    end
                end
                MD_DONE: begin
                    state   <= MD_IDLE;
                    md_done <= 1'b0;
                    md_busy <= 1'b0;
                    md_hold <= 1'b1;
                end
                default: begin
                    state   <= MD_IDLE;
                    count   <= '0;
                    md_done <= 1'b0;
                    md_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule
